// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: sequential instruction prefetch buffer in front of IF/ID.
// Issues word fetches over a req/ack handshake, buffers {inst, pc+4} pairs in a
// small FIFO, and flushes/restarts on a PC redirect. Requests are credit-limited
// so every ack always finds a free slot.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       Reset_n,
    input  logic                       Redirect,
    input  logic [31:0]                Redirect_PC,
    output logic                       Mem_req,
    output logic [31:0]                Mem_addr,
    input  logic                       Mem_ack,
    input  logic [31:0]                Mem_rdata,
    output logic                       Inst_valid,
    output logic [31:0]                Inst,
    output logic [31:0]                Inst_PCP4,
    input  logic                       Inst_take,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      fetch_pc;
    logic             discard;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pcp4_mem [DEPTH];
    logic [31:0]      redirect_word;
    logic             ack;
    logic             push;
    logic             pop;
    logic             issue;

    // Sequential word address; wraps modulo 2^32.
    function automatic logic [31:0] next_word(input logic [31:0] addr);
        return addr + 32'd4;
    endfunction

    assign redirect_word = Redirect_PC & 32'hFFFF_FFFC;

    // Handshake decode, occupancy update and credit check for the next request.
    // A new request may only start once no request is outstanding after this
    // edge, and only when the post-push/pop count leaves room for its data.
    always_comb begin
        ack       = Mem_req & Mem_ack;
        push      = ack & ~discard & ~Redirect;
        pop       = Inst_valid & Inst_take & ~Redirect;
        count_nxt = count;
        if (Redirect) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
        issue = ~Redirect & (~Mem_req | ack) & (count_nxt < CNT_W'(DEPTH));
    end

    // Control state: request handshake, fetch PC, stale-data flag, FIFO pointers.
    // A request that is still outstanding at a redirect is held until acked and
    // its data dropped; a redirect on the ack cycle simply drops the data.
    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            Mem_req  <= 1'b0;
            Mem_addr <= 32'h0;
            fetch_pc <= RESET_PC;
            discard  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            count <= count_nxt;
            if (Redirect) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fetch_pc <= redirect_word;
                discard  <= Mem_req & ~Mem_ack;
                Mem_req  <= Mem_req & ~Mem_ack;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (ack) begin
                    discard <= 1'b0;
                end
                Mem_req <= issue | (Mem_req & ~ack);
                if (issue) begin
                    Mem_addr <= fetch_pc;
                    fetch_pc <= next_word(fetch_pc);
                end
            end
        end
    end

    // Queue storage; contents are only meaningful below count, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= Mem_rdata;
            pcp4_mem[wr_ptr] <= next_word(Mem_addr);
        end
    end

    assign Count      = count;
    assign Inst_valid = (count != '0);
    assign Inst       = Inst_valid ? inst_mem[rd_ptr] : 32'h0;
    assign Inst_PCP4  = Inst_valid ? pcp4_mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed testbench for inst_fetch_queue (DEPTH=4, RESET_PC=0).
// Memory model returns the bitwise inverse of the requested address.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        Reset_n;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        Mem_req;
    logic [31:0] Mem_addr;
    logic        Mem_ack;
    logic [31:0] Mem_rdata;
    logic        Inst_valid;
    logic [31:0] Inst;
    logic [31:0] Inst_PCP4;
    logic        Inst_take;
    logic [2:0]  Count;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .Redirect   (Redirect),
        .Redirect_PC(Redirect_PC),
        .Mem_req    (Mem_req),
        .Mem_addr   (Mem_addr),
        .Mem_ack    (Mem_ack),
        .Mem_rdata  (Mem_rdata),
        .Inst_valid (Inst_valid),
        .Inst       (Inst),
        .Inst_PCP4  (Inst_PCP4),
        .Inst_take  (Inst_take),
        .Count      (Count)
    );

    always #5 clk = ~clk;

    assign Mem_rdata = ~Mem_addr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n     = 1'b0;
        Redirect    = 1'b0;
        Redirect_PC = 32'h0;
        Mem_ack     = 1'b0;
        Inst_take   = 1'b0;
        step();
        step();
        Reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        Reset_n     = 1'b0;
        Redirect    = 1'b0;
        Redirect_PC = 32'h0;
        Mem_ack     = 1'b0;
        Inst_take   = 1'b0;
        step();
        step();
        n_checks++; if (Mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", Mem_req); end
        n_checks++; if (Mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", Mem_addr); end
        n_checks++; if (Inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", Inst_valid); end
        n_checks++; if (Inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", Inst); end
        n_checks++; if (Inst_PCP4 !== 32'h0) begin n_fail++; $display("FAIL reset_pcp4: got %h expected 0", Inst_PCP4); end
        n_checks++; if (Count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", Count); end
    endtask

    task automatic test_stream();
        Reset_n = 1'b1;
        Mem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (Mem_req !== 1'b1 || Mem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_req%0d: got req=%b addr=%h expected req=1 addr=%h", i, Mem_req, Mem_addr, 32'(4 * i)); end
            n_checks++; if (Count !== 3'(i)) begin n_fail++; $display("FAIL stream_count%0d: got %0d expected %0d", i, Count, i); end
        end
        step();
        n_checks++; if (Mem_req !== 1'b0) begin n_fail++; $display("FAIL stream_full_req: got %b expected 0", Mem_req); end
        n_checks++; if (Count !== 3'd4) begin n_fail++; $display("FAIL stream_full_count: got %0d expected 4", Count); end
        n_checks++; if (Inst_PCP4 !== 32'h4 || Inst !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stream_head: got pcp4=%h inst=%h expected pcp4=4 inst=ffffffff", Inst_PCP4, Inst); end
        step();
        n_checks++; if (Mem_req !== 1'b0 || Count !== 3'd4) begin n_fail++; $display("FAIL stream_hold: got req=%b count=%0d expected req=0 count=4", Mem_req, Count); end
    endtask

    task automatic test_steady_flow();
        Mem_ack   = 1'b0;
        Inst_take = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (Inst_valid !== 1'b1 || Inst_PCP4 !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL drain_head%0d: got valid=%b pcp4=%h expected valid=1 pcp4=%h", i, Inst_valid, Inst_PCP4, 32'(4 * (i + 1))); end
            step();
        end
        n_checks++; if (Count !== 3'd0 || Mem_req !== 1'b1 || Mem_addr !== 32'h10) begin n_fail++; $display("FAIL drain_end: got count=%0d req=%b addr=%h expected count=0 req=1 addr=10", Count, Mem_req, Mem_addr); end
        Mem_ack = 1'b1;
        step();
        n_checks++; if (Count !== 3'd1 || Inst_PCP4 !== 32'h14 || Mem_addr !== 32'h14) begin n_fail++; $display("FAIL flow_first: got count=%0d pcp4=%h addr=%h expected count=1 pcp4=14 addr=14", Count, Inst_PCP4, Mem_addr); end
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++; if (Count !== 3'd1 || Inst_PCP4 !== 32'(32'h18 + 4 * i) || Mem_addr !== 32'(32'h18 + 4 * i)) begin n_fail++; $display("FAIL flow%0d: got count=%0d pcp4=%h addr=%h expected count=1 pcp4=%h addr=%h", i, Count, Inst_PCP4, Mem_addr, 32'(32'h18 + 4 * i), 32'(32'h18 + 4 * i)); end
        end
    endtask

    task automatic test_slow_memory();
        do_reset();
        Inst_take = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int w = 0; w < 2; w++) begin
                step();
                n_checks++; if (Mem_req !== 1'b1 || Mem_addr !== 32'(4 * k) || Inst_valid !== 1'b0) begin n_fail++; $display("FAIL slow_wait%0d_%0d: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0", k, w, Mem_req, Mem_addr, Inst_valid, 32'(4 * k)); end
            end
            Mem_ack = 1'b1;
            step();
            Mem_ack = 1'b0;
            n_checks++; if (Count !== 3'd1 || Inst_PCP4 !== 32'(4 * k + 4) || Inst !== ~32'(4 * k)) begin n_fail++; $display("FAIL slow_word%0d: got count=%0d pcp4=%h inst=%h expected count=1 pcp4=%h inst=%h", k, Count, Inst_PCP4, Inst, 32'(4 * k + 4), ~32'(4 * k)); end
        end
    endtask

    task automatic test_redirect_pending();
        do_reset();
        Mem_ack   = 1'b1;
        Inst_take = 1'b1;
        repeat (4) step();
        Mem_ack = 1'b0;
        step();
        n_checks++; if (Mem_req !== 1'b1 || Mem_addr !== 32'h10 || Count !== 3'd0) begin n_fail++; $display("FAIL rdp_setup: got req=%b addr=%h count=%0d expected req=1 addr=10 count=0", Mem_req, Mem_addr, Count); end
        Redirect    = 1'b1;
        Redirect_PC = 32'h103;
        step();
        Redirect = 1'b0;
        n_checks++; if (Mem_req !== 1'b1 || Mem_addr !== 32'h10 || Count !== 3'd0) begin n_fail++; $display("FAIL rdp_hold: got req=%b addr=%h count=%0d expected req=1 addr=10 count=0", Mem_req, Mem_addr, Count); end
        step();
        n_checks++; if (Mem_addr !== 32'h10) begin n_fail++; $display("FAIL rdp_hold2: got addr=%h expected 10", Mem_addr); end
        Mem_ack = 1'b1;
        step();
        Mem_ack = 1'b0;
        n_checks++; if (Mem_req !== 1'b1 || Mem_addr !== 32'h100 || Inst_valid !== 1'b0) begin n_fail++; $display("FAIL rdp_drop: got req=%b addr=%h valid=%b expected req=1 addr=100 valid=0", Mem_req, Mem_addr, Inst_valid); end
        step();
        Mem_ack = 1'b1;
        step();
        Mem_ack = 1'b0;
        n_checks++; if (Count !== 3'd1 || Inst_PCP4 !== 32'h104 || Inst !== ~32'h100) begin n_fail++; $display("FAIL rdp_first: got count=%0d pcp4=%h inst=%h expected count=1 pcp4=104 inst=%h", Count, Inst_PCP4, Inst, ~32'h100); end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        Mem_ack = 1'b1;
        step();
        step();
        n_checks++; if (Count !== 3'd2 || Mem_req !== 1'b1 || Mem_addr !== 32'h8) begin n_fail++; $display("FAIL rda_setup: got count=%0d req=%b addr=%h expected count=2 req=1 addr=8", Count, Mem_req, Mem_addr); end
        Redirect    = 1'b1;
        Redirect_PC = 32'h300;
        Inst_take   = 1'b1;
        step();
        Redirect  = 1'b0;
        Inst_take = 1'b0;
        Mem_ack   = 1'b0;
        n_checks++; if (Count !== 3'd0 || Mem_req !== 1'b0 || Inst_valid !== 1'b0) begin n_fail++; $display("FAIL rda_flush: got count=%0d req=%b valid=%b expected count=0 req=0 valid=0", Count, Mem_req, Inst_valid); end
        step();
        n_checks++; if (Mem_req !== 1'b1 || Mem_addr !== 32'h300) begin n_fail++; $display("FAIL rda_issue: got req=%b addr=%h expected req=1 addr=300", Mem_req, Mem_addr); end
        Mem_ack = 1'b1;
        step();
        n_checks++; if (Count !== 3'd1 || Inst_PCP4 !== 32'h304) begin n_fail++; $display("FAIL rda_word: got count=%0d pcp4=%h expected count=1 pcp4=304", Count, Inst_PCP4); end
    endtask

    task automatic test_reset_midstream();
        step();
        step();
        n_checks++; if (Count !== 3'd3 || Mem_req !== 1'b1 || Mem_addr !== 32'h30C) begin n_fail++; $display("FAIL rst_setup: got count=%0d req=%b addr=%h expected count=3 req=1 addr=30c", Count, Mem_req, Mem_addr); end
        Reset_n = 1'b0;
        step();
        n_checks++; if (Mem_req !== 1'b0 || Mem_addr !== 32'h0 || Count !== 3'd0) begin n_fail++; $display("FAIL rst_ctrl: got req=%b addr=%h count=%0d expected req=0 addr=0 count=0", Mem_req, Mem_addr, Count); end
        n_checks++; if (Inst_valid !== 1'b0 || Inst !== 32'h0 || Inst_PCP4 !== 32'h0) begin n_fail++; $display("FAIL rst_out: got valid=%b inst=%h pcp4=%h expected valid=0 inst=0 pcp4=0", Inst_valid, Inst, Inst_PCP4); end
        Reset_n = 1'b1;
        Mem_ack = 1'b0;
        step();
        n_checks++; if (Mem_req !== 1'b1 || Mem_addr !== 32'h0 || Count !== 3'd0) begin n_fail++; $display("FAIL rst_restart: got req=%b addr=%h count=%0d expected req=1 addr=0 count=0", Mem_req, Mem_addr, Count); end
    endtask

    task automatic test_wrap();
        Redirect    = 1'b1;
        Redirect_PC = 32'hFFFF_FFF8;
        Mem_ack     = 1'b1;
        step();
        Redirect = 1'b0;
        n_checks++; if (Mem_req !== 1'b0 || Count !== 3'd0) begin n_fail++; $display("FAIL wrap_flush: got req=%b count=%0d expected req=0 count=0", Mem_req, Count); end
        step();
        n_checks++; if (Mem_req !== 1'b1 || Mem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_a0: got req=%b addr=%h expected req=1 addr=fffffff8", Mem_req, Mem_addr); end
        step();
        n_checks++; if (Mem_addr !== 32'hFFFF_FFFC || Count !== 3'd1 || Inst_PCP4 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_a1: got addr=%h count=%0d pcp4=%h expected addr=fffffffc count=1 pcp4=fffffffc", Mem_addr, Count, Inst_PCP4); end
        step();
        n_checks++; if (Mem_addr !== 32'h0 || Count !== 3'd2) begin n_fail++; $display("FAIL wrap_a2: got addr=%h count=%0d expected addr=0 count=2", Mem_addr, Count); end
        Mem_ack   = 1'b0;
        Inst_take = 1'b1;
        step();
        Inst_take = 1'b0;
        n_checks++; if (Count !== 3'd1 || Inst_PCP4 !== 32'h0 || Inst !== 32'h3) begin n_fail++; $display("FAIL wrap_pcp4: got count=%0d pcp4=%h inst=%h expected count=1 pcp4=0 inst=3", Count, Inst_PCP4, Inst); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_steady_flow();
        test_slow_memory();
        test_redirect_pending();
        test_redirect_ack();
        test_reset_midstream();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
